// File: rtl/whack_mole_core.sv
// Whack-a-mole game engine: N-hole mole sequencing from an 8-bit LFSR,
// BCD score / miss / countdown, IDLE -> RUN (SPAWN/UP/GAP) -> OVER flow.
// All time bases advance only on clk edges where the tick strobe is high.
//
// state  | meaning
// IDLE   | after reset, waiting for a start rise
// SPAWN  | one clk: choose the next hole from the LFSR
// UP     | mole visible: waiting for hit, wrong press or escape
// GAP    | no mole shown, buttons ignored, waiting out the gap
// OVER   | round time expired, score/miss held until next start rise
module whack_mole_core #(
    parameter int          N_HOLES       = 4,
    parameter int          ROUND_SECS    = 60,
    parameter int          TICKS_PER_SEC = 10,
    parameter int          MOLE_TICKS    = 10,
    parameter int          GAP_TICKS     = 3,
    parameter logic [7:0]  LFSR_SEED     = 8'hA5
) (
    input  logic               clk,
    input  logic               clr,
    input  logic               tick,
    input  logic               start,
    input  logic [N_HOLES-1:0] button,
    output logic [N_HOLES-1:0] mole,
    output logic [7:0]         score_bcd,
    output logic [7:0]         miss_bcd,
    output logic [7:0]         time_bcd,
    output logic               running,
    output logic               game_over,
    output logic               hit_pulse
);

    localparam int         IDX_W     = $clog2(N_HOLES);
    localparam logic [7:0] ROUND_BCD = 8'(((ROUND_SECS / 10) << 4) | (ROUND_SECS % 10));
    localparam logic [7:0] TPS       = 8'(TICKS_PER_SEC);
    localparam logic [7:0] MOLE_LD   = 8'(MOLE_TICKS);
    localparam logic [7:0] GAP_LD    = 8'(GAP_TICKS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SPAWN,
        S_UP,
        S_GAP,
        S_OVER
    } state_t;

    state_t             state_q, state_n;
    logic [7:0]         lfsr_q, lfsr_n;
    logic               start_prev_q;
    logic [N_HOLES-1:0] button_prev_q;
    logic [IDX_W-1:0]   idx_q, idx_n, spawn_idx;
    logic [7:0]         mole_cnt_q, mole_cnt_n;
    logic [7:0]         gap_cnt_q, gap_cnt_n;
    logic [7:0]         sub_cnt_q, sub_cnt_n;
    logic [7:0]         score_q, score_n;
    logic [7:0]         miss_q, miss_n;
    logic [7:0]         time_q, time_n;
    logic [N_HOLES-1:0] mole_q, mole_n;
    logic               hit_q, hit_n;
    logic               running_q, running_n;
    logic               over_q, over_n;

    logic               start_rise;
    logic [N_HOLES-1:0] button_rise;
    logic [N_HOLES-1:0] mole_mask;
    logic               in_run;
    logic               hit;
    logic               wrong;
    logic               expire;

    function automatic logic [N_HOLES-1:0] onehot(input logic [IDX_W-1:0] i);
        logic [N_HOLES-1:0] r;
        r    = '0;
        r[i] = 1'b1;
        return r;
    endfunction

    // Counts stop at 99 rather than wrapping to 00.
    function automatic logic [7:0] bcd_inc_sat(input logic [7:0] v);
        if (v == 8'h99)
            return v;
        if (v[3:0] == 4'd9)
            return {v[7:4] + 4'd1, 4'd0};
        return v + 8'd1;
    endfunction

    function automatic logic [7:0] bcd_dec(input logic [7:0] v);
        if (v[3:0] == 4'd0)
            return {v[7:4] - 4'd1, 4'd9};
        return v - 8'd1;
    endfunction

    assign start_rise  = start & ~start_prev_q;
    assign button_rise = button & ~button_prev_q;
    assign mole_mask   = onehot(idx_q);
    assign in_run      = (state_q == S_SPAWN) || (state_q == S_UP) || (state_q == S_GAP);
    assign hit         = |(button_rise & mole_mask);
    assign wrong       = |(button_rise & ~mole_mask);
    assign lfsr_n      = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

    // Next-state, counters and registered-output values for the game flow.
    always_comb begin
        state_n    = state_q;
        idx_n      = idx_q;
        mole_cnt_n = mole_cnt_q;
        gap_cnt_n  = gap_cnt_q;
        sub_cnt_n  = sub_cnt_q;
        score_n    = score_q;
        miss_n     = miss_q;
        time_n     = time_q;
        mole_n     = '0;
        hit_n      = 1'b0;
        expire     = 1'b0;
        spawn_idx  = lfsr_q[IDX_W-1:0];
        if (spawn_idx == idx_q)
            spawn_idx = spawn_idx + 1'b1;

        if (in_run && tick) begin
            if (sub_cnt_q == TPS - 8'd1) begin
                sub_cnt_n = 8'd0;
                if (time_q == 8'h01) begin
                    time_n = 8'h00;
                    expire = 1'b1;
                end else begin
                    time_n = bcd_dec(time_q);
                end
            end else begin
                sub_cnt_n = sub_cnt_q + 8'd1;
            end
        end

        case (state_q)
            S_IDLE, S_OVER: begin
                if (start_rise) begin
                    score_n   = 8'h00;
                    miss_n    = 8'h00;
                    time_n    = ROUND_BCD;
                    sub_cnt_n = 8'd0;
                    state_n   = S_SPAWN;
                end
            end
            S_SPAWN: begin
                idx_n      = spawn_idx;
                mole_cnt_n = MOLE_LD;
                mole_n     = onehot(spawn_idx);
                state_n    = S_UP;
            end
            S_UP: begin
                mole_n = mole_mask;
                if (hit) begin
                    score_n   = bcd_inc_sat(score_q);
                    hit_n     = 1'b1;
                    mole_n    = '0;
                    gap_cnt_n = GAP_LD;
                    state_n   = S_GAP;
                end
                if (wrong)
                    miss_n = bcd_inc_sat(miss_q);
                if (!hit && !wrong && tick) begin
                    if (mole_cnt_q == 8'd1) begin
                        miss_n    = bcd_inc_sat(miss_q);
                        mole_n    = '0;
                        gap_cnt_n = GAP_LD;
                        state_n   = S_GAP;
                    end else begin
                        mole_cnt_n = mole_cnt_q - 8'd1;
                    end
                end
            end
            S_GAP: begin
                if (tick) begin
                    if (gap_cnt_q == 8'd1)
                        state_n = S_SPAWN;
                    else
                        gap_cnt_n = gap_cnt_q - 8'd1;
                end
            end
            default: state_n = S_IDLE;
        endcase

        // Running out of time wins over anything else that happened this cycle.
        if (expire) begin
            state_n = S_OVER;
            idx_n   = idx_q;
            score_n = score_q;
            miss_n  = miss_q;
            mole_n  = '0;
            hit_n   = 1'b0;
        end

        running_n = (state_n == S_SPAWN) || (state_n == S_UP) || (state_n == S_GAP);
        over_n    = (state_n == S_OVER);
    end

    // State and datapath registers; LFSR and edge detectors run every clk.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q       <= S_IDLE;
            lfsr_q        <= LFSR_SEED;
            start_prev_q  <= 1'b0;
            button_prev_q <= '0;
            idx_q         <= '0;
            mole_cnt_q    <= 8'd0;
            gap_cnt_q     <= 8'd0;
            sub_cnt_q     <= 8'd0;
            score_q       <= 8'h00;
            miss_q        <= 8'h00;
            time_q        <= ROUND_BCD;
            mole_q        <= '0;
            hit_q         <= 1'b0;
            running_q     <= 1'b0;
            over_q        <= 1'b0;
        end else begin
            state_q       <= state_n;
            lfsr_q        <= lfsr_n;
            start_prev_q  <= start;
            button_prev_q <= button;
            idx_q         <= idx_n;
            mole_cnt_q    <= mole_cnt_n;
            gap_cnt_q     <= gap_cnt_n;
            sub_cnt_q     <= sub_cnt_n;
            score_q       <= score_n;
            miss_q        <= miss_n;
            time_q        <= time_n;
            mole_q        <= mole_n;
            hit_q         <= hit_n;
            running_q     <= running_n;
            over_q        <= over_n;
        end
    end

    assign mole      = mole_q;
    assign score_bcd = score_q;
    assign miss_bcd  = miss_q;
    assign time_bcd  = time_q;
    assign running   = running_q;
    assign game_over = over_q;
    assign hit_pulse = hit_q;

endmodule

// File: tb/tb_whack_mole_core.sv
// Directed bench for whack_mole_core: a short 3 s round instance for game
// flow checks and a 99 s instance for score saturation.
module tb_whack_mole_core;

    logic       clk = 1'b0;
    logic       clr;
    logic       tick;
    logic       start;
    logic [3:0] button;
    logic [3:0] button2;

    logic [3:0] mole, mole2;
    logic [7:0] score, score2, miss, miss2, tim, tim2;
    logic       running, running2, over, over2, hit, hit2;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    whack_mole_core #(
        .N_HOLES(4), .ROUND_SECS(3), .TICKS_PER_SEC(2),
        .MOLE_TICKS(3), .GAP_TICKS(1), .LFSR_SEED(8'hA5)
    ) u_dut (
        .clk(clk), .clr(clr), .tick(tick), .start(start), .button(button),
        .mole(mole), .score_bcd(score), .miss_bcd(miss), .time_bcd(tim),
        .running(running), .game_over(over), .hit_pulse(hit)
    );

    whack_mole_core #(
        .N_HOLES(4), .ROUND_SECS(99), .TICKS_PER_SEC(10),
        .MOLE_TICKS(3), .GAP_TICKS(1), .LFSR_SEED(8'hA5)
    ) u_sat (
        .clk(clk), .clr(clr), .tick(tick), .start(start), .button(button2),
        .mole(mole2), .score_bcd(score2), .miss_bcd(miss2), .time_bcd(tim2),
        .running(running2), .game_over(over2), .hit_pulse(hit2)
    );

    always #5 clk = ~clk;

    // Reference LFSR (taps 8,6,5,4) and the value it held before the last edge.
    logic [7:0] m_lfsr, m_prev;
    always @(posedge clk or negedge clr) begin
        if (!clr) begin
            m_lfsr <= 8'hA5;
            m_prev <= 8'hA5;
        end else begin
            m_prev <= m_lfsr;
            m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
        end
    end

    // Predicts which hole each newly shown mole of u_dut should occupy.
    logic [1:0] m_pidx, m_e;
    logic [3:0] exp_mole, mole_seen;
    always @(negedge clk) begin
        if (!clr) begin
            m_pidx    = 2'd0;
            exp_mole  = 4'd0;
            mole_seen = 4'd0;
        end else begin
            if (mole != 4'd0 && mole_seen == 4'd0) begin
                m_e = m_prev[1:0];
                if (m_e == m_pidx)
                    m_e = m_e + 2'd1;
                m_pidx   = m_e;
                exp_mole = 4'b0001 << m_e;
            end
            mole_seen = mole;
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
        cyc++;
        tick = (cyc % 4 == 0);
    endtask

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] to_bcd(input int v);
        int s;
        s = (v > 99) ? 99 : v;
        return 8'(((s / 10) << 4) | (s % 10));
    endfunction

    initial begin
        int         n, gt, run_ticks, up_ticks, ph, hits;
        logic       ta;
        logic [3:0] mb, old_mole, w1, w2;

        clr = 1'b0; tick = 1'b0; start = 1'b0; button = 4'd0; button2 = 4'd0;
        step(); step();
        chk("rst_mole",    8'(mole),    8'h00);
        chk("rst_score",   score,       8'h00);
        chk("rst_miss",    miss,        8'h00);
        chk("rst_time",    tim,         8'h03);
        chk("rst_time99",  tim2,        8'h99);
        chk("rst_running", 8'(running), 8'h00);
        chk("rst_over",    8'(over),    8'h00);
        chk("rst_hit",     8'(hit),     8'h00);
        clr = 1'b1;
        step(); step();
        chk("idle_running", 8'(running), 8'h00);

        // first mole of round 1
        start = 1'b1;
        step();
        start = 1'b0;
        chk("p1_running",    8'(running), 8'h01);
        chk("p1_time",       tim,         8'h03);
        chk("p1_spawn_mole", 8'(mole),    8'h00);
        n = 0;
        while (mole == 4'd0 && n < 2) begin step(); n++; end
        chk("p1_mole_lat",   8'(n),               8'd1);
        chk("p1_onehot",     8'($countones(mole)), 8'd1);
        chk("p1_mole_hole",  8'(mole),            8'(exp_mole));
        old_mole = exp_mole;

        // hit the active hole
        button = exp_mole;
        step();
        chk("p2_hit_pulse", 8'(hit),  8'h01);
        chk("p2_score",     score,    8'h01);
        chk("p2_mole_off",  8'(mole), 8'h00);
        chk("p2_miss",      miss,     8'h00);
        button = 4'd0;
        gt = 0;
        ta = tick; step(); if (ta) gt++;
        chk("p2_pulse_once", 8'(hit), 8'h00);
        n = 0;
        while (mole == 4'd0 && n < 10) begin ta = tick; step(); if (ta) gt++; n++; end
        chk("p2_gap_ticks", 8'(gt),               8'd1);
        chk("p2_new_hole",  8'(mole),             8'(exp_mole));
        chk("p2_moved",     8'(mole != old_mole), 8'd1);

        // one wrong hole, then two wrong holes in one cycle
        w1 = {exp_mole[2:0], exp_mole[3]};
        w2 = w1 | {exp_mole[1:0], exp_mole[3:2]};
        if (tick) step();
        button = w1;
        step();
        chk("p3_miss1",  miss,     8'h01);
        chk("p3_mole1",  8'(mole), 8'(exp_mole));
        chk("p3_score1", score,    8'h01);
        button = 4'd0;
        step();
        if (tick) step();
        button = w2;
        step();
        chk("p3_miss2", miss,     8'h02);
        chk("p3_mole2", 8'(mole), 8'(exp_mole));
        button = 4'd0;

        n = 0;
        while (!over && n < 40) begin step(); n++; end
        chk("r1_over", 8'(over), 8'h01);

        // round 2: no presses, escape then expiry
        start = 1'b1;
        step();
        start = 1'b0;
        chk("p4_running", 8'(running), 8'h01);
        chk("p4_score",   score,       8'h00);
        chk("p4_miss0",   miss,        8'h00);
        chk("p4_time",    tim,         8'h03);
        chk("p4_over0",   8'(over),    8'h00);
        run_ticks = 0; up_ticks = 0; ph = 0; n = 0;
        while (!over && n < 60) begin
            mb = mole; ta = tick;
            step();
            n++;
            if (ta) run_ticks++;
            if (ph == 0 && mb != 4'd0) begin
                if (ta) up_ticks++;
                if (mole == 4'd0) begin
                    ph = 1;
                    chk("p4_escape_ticks", 8'(up_ticks), 8'd3);
                    chk("p4_escape_miss",  miss,         8'h01);
                end
            end
        end
        chk("p4_escaped",    8'(ph),        8'd1);
        chk("p4_run_ticks",  8'(run_ticks), 8'd6);
        chk("p4_over",       8'(over),      8'h01);
        chk("p4_time0",      tim,           8'h00);
        chk("p4_mole0",      8'(mole),      8'h00);
        chk("p4_not_run",    8'(running),   8'h00);

        button = 4'hF;
        step();
        button = 4'd0;
        step();
        chk("over_score", score,    8'h00);
        chk("over_miss",  miss,     8'h01);
        chk("over_mole",  8'(mole), 8'h00);
        chk("over_held",  8'(over), 8'h01);
        chk("over_time",  tim,      8'h00);
        chk("over_hit",   8'(hit),  8'h00);

        // restart from OVER, score once, then asynchronous clear
        start = 1'b1;
        step();
        start = 1'b0;
        chk("p5_score",   score,       8'h00);
        chk("p5_miss",    miss,        8'h00);
        chk("p5_time",    tim,         8'h03);
        chk("p5_running", 8'(running), 8'h01);
        chk("p5_over",    8'(over),    8'h00);
        n = 0;
        while (mole == 4'd0 && n < 4) begin step(); n++; end
        chk("p5_mole", 8'(mole), 8'(exp_mole));
        button = exp_mole;
        step();
        button = 4'd0;
        chk("p5_hit_score", score, 8'h01);
        #1;
        clr = 1'b0;
        #1;
        chk("clr_mole",    8'(mole),    8'h00);
        chk("clr_score",   score,       8'h00);
        chk("clr_miss",    miss,        8'h00);
        chk("clr_time",    tim,         8'h03);
        chk("clr_running", 8'(running), 8'h00);
        chk("clr_over",    8'(over),    8'h00);
        chk("clr_hit",     8'(hit),     8'h00);
        step(); step();
        clr = 1'b1;
        step();

        // long round: score saturation at 99
        start = 1'b1;
        step();
        start = 1'b0;
        hits = 0;
        for (int h = 0; h < 120; h++) begin
            n = 0;
            while (mole2 == 4'd0 && n < 12) begin step(); n++; end
            button2 = mole2;
            step();
            hits++;
            chk("p6_score", score2,    to_bcd(hits));
            chk("p6_pulse", 8'(hit2),  8'h01);
            if (hits == 10)
                chk("p6_roll_09_10", score2, 8'h10);
            button2 = 4'd0;
            step();
        end
        chk("p6_sat",     score2,       8'h99);
        chk("p6_miss",    miss2,        8'h00);
        chk("p6_running", 8'(running2), 8'h01);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
